// File: rtl/text_pixel_fetch.sv
// Display front-end: turns scan coordinates into a VRAM fetch and, in text mode, a font-ROM fetch.
// All outputs are delay-matched so a pixel sampled at edge k appears on every output after edge k+4.
module text_pixel_fetch #(
    parameter int COLS    = 80,
    parameter int ROWS    = 30,
    parameter int GCOLS   = 160,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        graph_mode_in,
    output logic [14:0] vram_addr,
    input  logic [15:0] vram_data,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    output logic        graph_mode,
    output logic [15:0] char_color,
    output logic        font_dot,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        video_on_out
);
    // Streaming pipeline: one pixel accepted and one produced every clock, no valid/ready,
    // no backpressure; VRAM and font ROM must answer exactly one clock after their address.

    localparam int COL_W  = $clog2(COLS);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int GCOL_W = $clog2(GCOLS);

    typedef struct packed {
        logic       von;
        logic       hs;
        logic       vs;
        logic       mode;
        logic [2:0] xl;
        logic [3:0] yl;
    } side_t;

    localparam side_t SIDE_RST = '{von: 1'b0, hs: 1'b1, vs: 1'b1, mode: 1'b0, xl: 3'd0, yl: 4'd0};

    // Constant multiply expanded into shifted adds over the set bits of k.
    function automatic logic [14:0] mul_const(input logic [14:0] v, input int k);
        logic [14:0] acc;
        acc = '0;
        for (int b = 0; b < 16; b++) begin
            if (k[b]) acc = acc + (v << b);
        end
        return acc;
    endfunction

    logic        mode_q;
    logic        frame_start;
    logic        mode_eff;
    logic [14:0] addr_next;
    side_t       sb [LATENCY];
    logic [15:0] word_q;
    logic [15:0] word_d;

    // Pixel (0,0) must already see the new mode, so the latch is bypassed on that clock.
    assign frame_start = video_on && (pix_x == '0) && (pix_y == '0);
    assign mode_eff    = frame_start ? graph_mode_in : mode_q;

    always_comb begin
        addr_next = '0;
        if (video_on) begin
            if (mode_eff) begin
                addr_next = mul_const(15'(pix_y[9:2]), GCOLS) + 15'(pix_x[2 +: GCOL_W]);
            end else begin
                addr_next = mul_const(15'(pix_y[4 +: ROW_W]), COLS) + 15'(pix_x[3 +: COL_W]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q       <= 1'b0;
            vram_addr    <= '0;
            font_addr    <= '0;
            word_q       <= '0;
            word_d       <= '0;
            graph_mode   <= 1'b0;
            char_color   <= '0;
            font_dot     <= 1'b0;
            hsync_out    <= 1'b1;
            vsync_out    <= 1'b1;
            video_on_out <= 1'b0;
            for (int i = 0; i < LATENCY; i++) begin
                sb[i] <= SIDE_RST;
            end
        end else begin
            mode_q    <= mode_eff;
            vram_addr <= addr_next;
            sb[0]     <= '{von: video_on, hs: hsync_in, vs: vsync_in, mode: mode_eff,
                           xl: pix_x[2:0], yl: pix_y[3:0]};
            for (int i = 1; i < LATENCY; i++) begin
                sb[i] <= sb[i-1];
            end

            // Stage after the RAM: vram_data belongs to the pixel now held in sb[1].
            word_q    <= vram_data;
            font_addr <= {vram_data[7:0], sb[1].yl};
            word_d    <= word_q;

            graph_mode   <= sb[LATENCY-1].mode;
            hsync_out    <= sb[LATENCY-1].hs;
            vsync_out    <= sb[LATENCY-1].vs;
            video_on_out <= sb[LATENCY-1].von;
            if (!sb[LATENCY-1].von) begin
                char_color <= '0;
                font_dot   <= 1'b0;
            end else if (sb[LATENCY-1].mode) begin
                char_color <= {8'h00, word_d[7:0]};
                font_dot   <= 1'b0;
            end else begin
                char_color <= word_d;
                font_dot   <= font_data[3'd7 - sb[LATENCY-1].xl];
            end
        end
    end

endmodule

// File: tb/tb_text_pixel_fetch.sv
// Randomized bench for text_pixel_fetch: a cycle-level reference model pushes expected
// outputs per issued pixel; a negedge monitor pops and compares as outputs come due.
module tb_text_pixel_fetch;

    localparam int COLS  = 80;
    localparam int GCOLS = 160;
    localparam logic [20:0] BLANK = {1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic        video_on = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic        graph_mode_in = 1'b0;
    logic [14:0] vram_addr;
    logic [15:0] vram_data;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic        graph_mode;
    logic [15:0] char_color;
    logic        font_dot;
    logic        hsync_out;
    logic        vsync_out;
    logic        video_on_out;

    logic [15:0] vram [0:32767];
    logic [7:0]  font [0:4095];

    logic [20:0] exp_q[$];
    logic [14:0] addr_q[$];
    logic [12:0] fa_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit model_mode = 1'b0;

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    text_pixel_fetch dut (
        .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .video_on(video_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .graph_mode_in(graph_mode_in),
        .vram_addr(vram_addr), .vram_data(vram_data), .font_addr(font_addr),
        .font_data(font_data), .graph_mode(graph_mode), .char_color(char_color),
        .font_dot(font_dot), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .video_on_out(video_on_out)
    );

    // external synchronous memories, one clock of read latency
    always @(posedge clk) begin
        vram_data <= vram[vram_addr];
        font_data <= font[font_addr];
    end

    // driver + reference model
    task automatic drive(input bit rst, input bit von, input bit hs, input bit vs,
                         input int x, input int y, input bit gmi);
        int a;
        int w;
        int row;
        bit m;
        logic [15:0] cc;
        bit dot;
        @(posedge clk);
        #2;
        rst_n = !rst;
        video_on = von;
        hsync_in = hs;
        vsync_in = vs;
        pix_x = 10'(x);
        pix_y = 10'(y);
        graph_mode_in = gmi;
        if (rst) begin
            model_mode = 1'b0;
            for (int i = 0; i < 4 && i < exp_q.size(); i++) exp_q[exp_q.size()-1-i] = BLANK;
            exp_q.push_back(BLANK);
            addr_q.push_back(15'd0);
            foreach (fa_q[i]) fa_q[i][12] = 1'b0;
            fa_q.push_back(13'd0);
        end else begin
            if (von && x == 0 && y == 0) model_mode = gmi;
            m = model_mode;
            if (!von) a = 0;
            else if (m) a = ((y / 4) * GCOLS + x / 4) % 32768;
            else a = (((y / 16) % 32) * COLS + x / 8) % 32768;
            w = int'(vram[a]);
            row = int'(font[(w % 256) * 16 + y % 16]);
            if (!von) begin
                cc = 16'h0000;
                dot = 1'b0;
            end else if (m) begin
                cc = 16'(w % 256);
                dot = 1'b0;
            end else begin
                cc = 16'(w);
                dot = row[7 - x % 8];
            end
            exp_q.push_back({m, cc, dot, hs, vs, von});
            addr_q.push_back(15'(a));
            fa_q.push_back({1'b1, 12'((w % 256) * 16 + y % 16)});
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [20:0] e;
        logic [20:0] got;
        logic [14:0] ea;
        logic [12:0] ef;
        if (exp_q.size() >= 6) begin
            e = exp_q.pop_front();
            got = {graph_mode, char_color, font_dot, hsync_out, vsync_out, video_on_out};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL outputs @%0t: got gm=%b cc=%h dot=%b hs=%b vs=%b von=%b, expected gm=%b cc=%h dot=%b hs=%b vs=%b von=%b",
                         $time, got[20], got[19:4], got[3], got[2], got[1], got[0],
                         e[20], e[19:4], e[3], e[2], e[1], e[0]);
            end
        end
        if (addr_q.size() >= 2) begin
            ea = addr_q.pop_front();
            n_checks++;
            if (vram_addr !== ea) begin
                n_fail++;
                $display("FAIL vram_addr @%0t: got %0d expected %0d", $time, vram_addr, ea);
            end
        end
        if (fa_q.size() >= 4) begin
            ef = fa_q.pop_front();
            if (ef[12]) begin
                n_checks++;
                if (font_addr !== ef[11:0]) begin
                    n_fail++;
                    $display("FAIL font_addr @%0t: got %h expected %h", $time, font_addr, ef[11:0]);
                end
            end
        end
    end

    // stimulus
    initial begin
        for (int i = 0; i < 32768; i++) vram[i] = 16'($urandom);
        for (int i = 0; i < 4096; i++) font[i] = 8'($urandom);
        vram[81] = 16'h1E41;
        font[12'h413] = 8'b0011_1100;
        vram[161] = 16'h00E3;

        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                  $urandom_range(1023), $urandom_range(1023), 1'($urandom_range(1)));
        for (int i = 0; i < 10; i++)
            drive(1'b0, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)),
                  $urandom_range(639), $urandom_range(479), 1'($urandom_range(1)));

        // text fetch
        drive(1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0);
        for (int x = 8; x <= 15; x++) drive(1'b0, 1'b1, 1'b1, 1'b1, x, 19, 1'b0);
        for (int i = 0; i < 150; i++)
            drive(1'b0, 1'b1, 1'b1, 1'b1, 1 + $urandom_range(638), $urandom_range(479),
                  1'($urandom_range(1)));

        // mid-frame mode request ignored, then switch at next (0,0)
        drive(1'b0, 1'b1, 1'b1, 1'b1, 320, 240, 1'b1);
        for (int i = 0; i < 30; i++)
            drive(1'b0, 1'b1, 1'b1, 1'b1, 1 + $urandom_range(638), $urandom_range(479), 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 1'b1);
        for (int y = 4; y <= 7; y++)
            for (int x = 4; x <= 7; x++) drive(1'b0, 1'b1, 1'b1, 1'b1, x, y, 1'b1);
        for (int i = 0; i < 150; i++)
            drive(1'b0, 1'b1, 1'b1, 1'b1, 1 + $urandom_range(638), $urandom_range(479),
                  1'($urandom_range(1)));

        // blanking with a 96-clock hsync pulse
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 640 + i, 100, 1'b0);
        for (int i = 0; i < 96; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 656 + i, 100, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 752 + i, 100, 1'b0);

        // reset for one clock at x=200 mid-line
        for (int x = 190; x <= 220; x++) drive(x == 200, 1'b1, 1'b1, 1'b1, x, 100, 1'b1);

        // random mix including out-of-range coordinates and sporadic resets
        for (int i = 0; i < 600; i++) begin
            bit r;
            int x;
            int y;
            r = ($urandom_range(59) == 0);
            x = $urandom_range(639);
            y = $urandom_range(479);
            if ($urandom_range(7) == 0) begin
                x = $urandom_range(1023);
                y = $urandom_range(1023);
            end
            if ($urandom_range(19) == 0) begin
                x = 0;
                y = 0;
            end
            drive(r, $urandom_range(3) != 0, 1'($urandom_range(1)), 1'($urandom_range(1)),
                  x, y, 1'($urandom_range(1)));
        end

        // flush the pipeline
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
